div_tick_ctrl: RTL and testbench

DIV_TICK_CTRL -- requirements
Module: div_tick_ctrl

---
 rtl/div_tick_pkg.sv | 15 +
 rtl/div_mod_cnt.sv | 29 ++
 rtl/div_tick_ctrl.sv | 133 +++++++++++++
 tb/tb_div_tick_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_tick_pkg.sv
// Shared definitions for the divided-tick burst controller:
// FSM state encoding and the configuration values restored on reset.
package div_tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Stored divisor and burst count after reset
  localparam int RST_DIV   = 3;
  localparam int RST_COUNT = 1;

endpackage

// File: rtl/div_mod_cnt.sv
// Modulo-N phase counter with synchronous clear and count enable.
// wrap flags the last phase of a period (phase == modulus-1); the
// caller guarantees modulus >= 1.
module div_mod_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] phase,
  output logic         wrap
);

  assign wrap = (phase == (modulus - W'(1)));

  // Phase register: clear wins over counting, wraps to 0 after modulus-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= wrap ? '0 : phase + W'(1);
    end
  end

endmodule

// File: rtl/div_tick_ctrl.sv
// Divided-tick burst controller.
// Emits a one-cycle tick every N cycles while in RUN, counts the ticks,
// and finishes the burst with a one-cycle done pulse once the configured
// number of ticks has been produced and the current period has ended.
// Optional build macro DIV_TICK_CTRL_CONT_EN: when defined, cfg_count==0
// means continuous mode (run until abort); otherwise 0 behaves as 1.
//
// state | meaning
// IDLE  | waiting; configuration accepted, start launches a burst
// RUN   | phase counter running, ticks emitted on phase 0
// DONE  | single cycle burst-complete indication
module div_tick_ctrl
  import div_tick_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             abort,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_count
);

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   count_q;
  logic [DIV_W-1:0]   div_eff;
  logic [DIV_W-1:0]   phase;
  logic               wrap;
  logic               cfg_load;
  logic               start_go;
  logic               run_tick;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   cnt_after;
  logic               complete;

  assign cfg_load = cfg_valid && (state == IDLE);
  assign start_go = (state == IDLE) && start && !abort;
  assign run_tick = (state == RUN) && (phase == '0);

  // Divisors 0 and 1 both mean a tick on every RUN cycle
  assign div_eff = (div_q <= DIV_W'(1)) ? DIV_W'(1) : div_q;

  // Tick count as it will stand after this cycle, saturating at all-ones
  assign cnt_inc   = (&tick_count) ? tick_count : tick_count + CNT_W'(1);
  assign cnt_after = run_tick ? cnt_inc : tick_count;

`ifdef DIV_TICK_CTRL_CONT_EN
  assign complete = wrap && (count_q != '0) && (cnt_after >= count_q);
`else
  assign complete = wrap &&
                    (cnt_after >= ((count_q == '0) ? CNT_W'(1) : count_q));
`endif

  div_mod_cnt #(
    .W (DIV_W)
  ) u_mod_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_go),
    .en      (state == RUN),
    .modulus (div_eff),
    .phase   (phase),
    .wrap    (wrap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and Moore outputs; abort outranks completion in RUN
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    tick      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (start && !abort) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        tick = run_tick;
        if (abort)         state_nxt = IDLE;
        else if (complete) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration registers, written only through the IDLE handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= DIV_W'(RST_DIV);
      count_q <= CNT_W'(RST_COUNT);
    end else if (cfg_load) begin
      div_q   <= cfg_div;
      count_q <= cfg_count;
    end
  end

  // Tick counter: cleared on burst launch, held after the burst ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_count <= '0;
    end else if (start_go) begin
      tick_count <= '0;
    end else if (run_tick) begin
      tick_count <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Bench for div_tick_ctrl: table of directed bursts, hand-written corner
// sequences (reset, start+abort, async reset mid-burst, continuous mode)
// and random bursts, all checked cycle by cycle against an arithmetic
// model of the burst timeline.
module tb_div_tick_ctrl;

  localparam int DIV_W = 8;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_count;
  logic             start;
  logic             abort;
  logic             tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] tick_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_div = 3;
  int cur_cnt = 1;

  always #5 clk = ~clk;

  div_tick_ctrl #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_count  (cfg_count),
    .start      (start),
    .abort      (abort),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .tick_count (tick_count)
  );

  typedef struct {
    string name;
    bit    use_cfg;
    int    div;
    int    cnt;
    int    abort_at;
    int    junk_at;
    int    exp_ticks;
    int    exp_done;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int min_sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic int eff_div(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  // Burst length in RUN cycles; 0 means continuous
  function automatic int run_len(input int d, input int c);
`ifdef DIV_TICK_CTRL_CONT_EN
    if (c == 0) return 0;
`else
    if (c == 0) return eff_div(d);
`endif
    return c * eff_div(d);
  endfunction

  // Launch a burst at cycle 0 and check cycles 1 .. end+2 against the model:
  // RUN occupies cycles 1..L (or 1..abort cycle), ticks fall on cycles
  // 1, 1+N, 1+2N..., done follows in cycle L+1 unless aborted.
  task automatic run_burst(input string tag, input bit use_cfg, input int div,
                           input int cnt, input int abort_at, input int junk_at,
                           output int nticks, output int done_cyc, output int fcnt);
    int  n, c, len, end_run, e_cnt;
    bit  aborted;
    bit  e_busy, e_tick, e_done;
    @(posedge clk); #1;
    if (use_cfg) begin
      cfg_valid = 1'b1;
      cfg_div   = DIV_W'(div);
      cfg_count = CNT_W'(cnt);
      cur_div   = div;
      cur_cnt   = cnt;
    end
    start = 1'b1;
    n   = eff_div(cur_div);
    len = run_len(cur_div, cur_cnt);
    c   = (cur_cnt == 0) ? 1 : cur_cnt;
    aborted = (abort_at != 0) && (len == 0 || abort_at <= len);
    end_run = aborted ? abort_at : len;
    @(negedge clk);
    check($sformatf("%s cfg_ready t=0", tag), int'(cfg_ready), 1);
    nticks   = 0;
    done_cyc = 0;
    for (int t = 1; t <= end_run + 2; t++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      cfg_valid = 1'b0;
      abort     = (t == abort_at);
      if (t == junk_at) begin
        cfg_valid = 1'b1;
        cfg_div   = DIV_W'(2);
        cfg_count = CNT_W'(5);
      end
      @(negedge clk);
      if (t <= end_run) begin
        e_busy = 1'b1;
        e_tick = ((t - 1) % n) == 0;
        e_done = 1'b0;
        e_cnt  = min_sat((t - 1 + n - 1) / n);
      end else begin
        e_busy = 1'b0;
        e_tick = 1'b0;
        e_done = !aborted && (t == len + 1);
        e_cnt  = aborted ? min_sat((abort_at - 1) / n + 1) : c;
      end
      check($sformatf("%s busy t=%0d", tag, t), int'(busy), int'(e_busy));
      check($sformatf("%s tick t=%0d", tag, t), int'(tick), int'(e_tick));
      check($sformatf("%s done t=%0d", tag, t), int'(done), int'(e_done));
      check($sformatf("%s cfg_ready t=%0d", tag, t), int'(cfg_ready),
            int'(!e_busy && !e_done));
      check($sformatf("%s tick_count t=%0d", tag, t), int'(tick_count), e_cnt);
      if (tick) nticks++;
      if (done) done_cyc = t;
    end
    abort     = 1'b0;
    cfg_valid = 1'b0;
    fcnt      = int'(tick_count);
  endtask

  initial begin
    int nt, dc, fc;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_count = '0;
    start     = 1'b1;
    abort     = 1'b0;

    // Outputs held at reset values, start ignored while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst tick", int'(tick), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst cfg_ready", int'(cfg_ready), 1);
    check("rst tick_count", int'(tick_count), 0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back('{"default",   1'b0, 0, 0, 0, 0, 1, 4, 1});
    vecs.push_back('{"d3c2",      1'b1, 3, 2, 0, 0, 2, 7, 2});
    vecs.push_back('{"d0c4",      1'b1, 0, 4, 0, 0, 4, 5, 4});
    vecs.push_back('{"abort",     1'b1, 5, 3, 3, 0, 1, 0, 1});
    vecs.push_back('{"d1c3",      1'b1, 1, 3, 0, 0, 3, 4, 3});
    vecs.push_back('{"d4c2ab6",   1'b1, 4, 2, 6, 0, 2, 0, 2});
    vecs.push_back('{"cfg_in_run",1'b1, 7, 1, 0, 3, 1, 8, 1});
    vecs.push_back('{"kept_cfg",  1'b0, 0, 0, 0, 0, 1, 8, 1});
`ifndef DIV_TICK_CTRL_CONT_EN
    vecs.push_back('{"c0_single", 1'b1, 2, 0, 0, 0, 1, 3, 1});
`endif

    foreach (vecs[i]) begin
      run_burst(vecs[i].name, vecs[i].use_cfg, vecs[i].div, vecs[i].cnt,
                vecs[i].abort_at, vecs[i].junk_at, nt, dc, fc);
      check({vecs[i].name, " ticks"}, nt, vecs[i].exp_ticks);
      check({vecs[i].name, " done cycle"}, dc, vecs[i].exp_done);
      check({vecs[i].name, " final count"}, fc, vecs[i].exp_cnt);
    end

    // start together with abort in IDLE must not launch a burst
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check($sformatf("start_abort busy k=%0d", k), int'(busy), 0);
      check($sformatf("start_abort ready k=%0d", k), int'(cfg_ready), 1);
      check($sformatf("start_abort tick k=%0d", k), int'(tick), 0);
    end

    // Asynchronous reset on a tick cycle mid-burst (div 7: ticks at 1 and 8)
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(7);
    cfg_count = CNT_W'(2);
    start     = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      start     = 1'b0;
    end
    check("pre_rst tick", int'(tick), 1);
    check("pre_rst tick_count", int'(tick_count), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst tick", int'(tick), 0);
    check("async_rst busy", int'(busy), 0);
    check("async_rst tick_count", int'(tick_count), 0);
    check("async_rst done", int'(done), 0);
    check("async_rst cfg_ready", int'(cfg_ready), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_rst done", int'(done), 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    cur_div = 3;
    cur_cnt = 1;
    run_burst("post_rst", 1'b0, 0, 0, 0, 0, nt, dc, fc);
    check("post_rst ticks", nt, 1);
    check("post_rst done cycle", dc, 4);
    check("post_rst final count", fc, 1);

`ifdef DIV_TICK_CTRL_CONT_EN
    // Continuous mode: div 2 for 600 cycles, then abort
    run_burst("cont", 1'b1, 2, 0, 600, 0, nt, dc, fc);
    check("cont ticks", nt, 300);
    check("cont done cycle", dc, 0);
    check("cont final count", fc, SAT);
`endif

    // Random bursts against the model
    for (int r = 0; r < 30; r++) begin
      bit use_cfg;
      int d, c, dd, cc, len, ab;
      use_cfg = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 6);
`ifdef DIV_TICK_CTRL_CONT_EN
      c = $urandom_range(1, 5);
`else
      c = $urandom_range(0, 5);
`endif
      dd  = use_cfg ? d : cur_div;
      cc  = use_cfg ? c : cur_cnt;
      len = run_len(dd, cc);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      run_burst($sformatf("rnd%0d", r), use_cfg, d, c, ab, 0, nt, dc, fc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
